// File: rtl/axi_lite_dma_pkg.sv
// Shared definitions for the DMA control register slave: register map,
// STATUS bit positions, AXI response codes and handshake FSM states.
package axi_lite_dma_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_SRC    = 8'h10;
  localparam logic [7:0] OFF_DST    = 8'h14;
  localparam logic [7:0] OFF_LEN    = 8'h18;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_IDLE_BIT = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [2:0] {
    SEL_CTRL   = 3'd0,
    SEL_STATUS = 3'd1,
    SEL_SRC    = 3'd2,
    SEL_DST    = 3'd3,
    SEL_LEN    = 3'd4,
    SEL_NONE   = 3'd5
  } reg_sel_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite handshake engine: collects AW/W in any order, issues one B per
// write, and answers reads one cycle after the AR handshake.
module axi_lite_slave_if
  import axi_lite_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      o_wr_en,
  output logic [ADDR_WIDTH-1:0]     o_wr_addr,
  output logic [DATA_WIDTH-1:0]     o_wr_data,
  output logic [DATA_WIDTH/8-1:0]   o_wr_strb,
  input  logic                      i_wr_err,
  output logic                      o_rd_en,
  output logic [ADDR_WIDTH-1:0]     o_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_rd_data,
  input  logic                      i_rd_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  wr_state_e               r_wr_state;
  rd_state_e               r_rd_state;
  logic                    r_awready, r_wready, r_bvalid;
  logic                    r_arready, r_rvalid;
  logic [1:0]              r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;
  logic                    w_aw_hs, w_w_hs, w_ar_hs;

  // A held channel stands in for a live handshake when assembling the write
  always_comb begin
    w_aw_hs   = s_axi_awvalid & r_awready;
    w_w_hs    = s_axi_wvalid & r_wready;
    w_ar_hs   = s_axi_arvalid & r_arready;
    o_wr_en   = (r_wr_state == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    o_wr_addr = r_aw_held ? r_awaddr : s_axi_awaddr;
    o_wr_data = r_w_held ? r_wdata : s_axi_wdata;
    o_wr_strb = r_w_held ? r_wstrb : s_axi_wstrb;
    o_rd_en   = w_ar_hs;
    o_rd_addr = s_axi_araddr;
  end

  // Write FSM
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_state <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (o_wr_en) begin
            r_wr_state <= W_RESP;
            r_bvalid   <= 1'b1;
            r_bresp    <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
          end else begin
            if (w_aw_hs) begin
              r_aw_held <= 1'b1;
              r_awaddr  <= s_axi_awaddr;
            end
            if (w_w_hs) begin
              r_w_held <= 1'b1;
              r_wdata  <= s_axi_wdata;
              r_wstrb  <= s_axi_wstrb;
            end
            r_awready <= ~(r_aw_held | w_aw_hs);
            r_wready  <= ~(r_w_held | w_w_hs);
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            r_wr_state <= W_IDLE;
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
          end
        end
        default: begin
          r_wr_state <= W_IDLE;
          r_bvalid   <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rd_state <= R_DATA;
            r_rdata    <= i_rd_data;
            r_rresp    <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
            r_rvalid   <= 1'b1;
            r_arready  <= 1'b0;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            r_rd_state <= R_IDLE;
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
          end
        end
        default: begin
          r_rd_state <= R_IDLE;
          r_rvalid   <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

endmodule

// File: rtl/axi_lite_dma_ctrl_slave.sv
// Control/status register bank for the MM2S->S2MM copy engine behind an
// AXI4-Lite slave port: SRC/DST/LEN configuration, START pulse, DONE/IDLE.
module axi_lite_dma_ctrl_slave
  import axi_lite_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    start_o,
  output logic [31:0]             src_addr_o,
  output logic [31:0]             dst_addr_o,
  output logic [LEN_WIDTH-1:0]    len_o,
  input  logic                    done_i
);

  logic                    w_wr_en, w_wr_err, w_rd_en, w_rd_err;
  logic [ADDR_WIDTH-1:0]   w_wr_addr, w_rd_addr;
  logic [31:0]             w_wr_data, w_rd_data;
  logic [3:0]              w_wr_strb;
  reg_sel_e                w_wr_sel, w_rd_sel;

  logic [31:0]             r_src, r_dst;
  logic [LEN_WIDTH-1:0]    r_len;
  logic                    r_done, r_idle, r_start;

  // Only word-aligned offsets inside the low 256 bytes are mapped
  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] a);
    reg_sel_e sel;
    if (a[ADDR_WIDTH-1:8] == '0) begin
      case (a[7:0])
        OFF_CTRL:   sel = SEL_CTRL;
        OFF_STATUS: sel = SEL_STATUS;
        OFF_SRC:    sel = SEL_SRC;
        OFF_DST:    sel = SEL_DST;
        OFF_LEN:    sel = SEL_LEN;
        default:    sel = SEL_NONE;
      endcase
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

  axi_lite_slave_if #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .o_wr_en       (w_wr_en),
    .o_wr_addr     (w_wr_addr),
    .o_wr_data     (w_wr_data),
    .o_wr_strb     (w_wr_strb),
    .i_wr_err      (w_wr_err),
    .o_rd_en       (w_rd_en),
    .o_rd_addr     (w_rd_addr),
    .i_rd_data     (w_rd_data),
    .i_rd_err      (w_rd_err)
  );

  // Address decode and read mux; reads see the register values before any same-edge write
  always_comb begin
    w_wr_sel  = decode(w_wr_addr);
    w_rd_sel  = decode(w_rd_addr);
    w_wr_err  = (w_wr_sel == SEL_NONE);
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    if (w_rd_en) begin
      case (w_rd_sel)
        SEL_CTRL:   w_rd_data = '0;
        SEL_STATUS: begin
          w_rd_data[STAT_DONE_BIT] = r_done;
          w_rd_data[STAT_IDLE_BIT] = r_idle;
        end
        SEL_SRC:    w_rd_data = r_src;
        SEL_DST:    w_rd_data = r_dst;
        SEL_LEN:    w_rd_data = 32'(r_len);
        default:    w_rd_err  = 1'b1;
      endcase
    end else begin
      w_rd_data = '0;
      w_rd_err  = 1'b0;
    end
  end

  // Register bank; done_i is applied last so it overrides a same-edge DONE clear
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
      r_idle  <= 1'b1;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_wr_en) begin
        case (w_wr_sel)
          SEL_CTRL: begin
            if (w_wr_strb[0] && w_wr_data[0] && r_idle) begin
              r_start <= 1'b1;
              r_idle  <= 1'b0;
              r_done  <= 1'b0;
            end
          end
          SEL_STATUS: begin
            if (w_wr_strb[0] && w_wr_data[STAT_DONE_BIT]) begin
              r_done <= 1'b0;
            end
          end
          SEL_SRC: r_src <= apply_wstrb(r_src, w_wr_data, w_wr_strb);
          SEL_DST: r_dst <= apply_wstrb(r_dst, w_wr_data, w_wr_strb);
          SEL_LEN: r_len <= LEN_WIDTH'(apply_wstrb(32'(r_len), w_wr_data, w_wr_strb));
          default: ;
        endcase
      end
      if (done_i) begin
        r_done <= 1'b1;
        r_idle <= 1'b1;
      end
    end
  end

  assign start_o    = r_start;
  assign src_addr_o = r_src;
  assign dst_addr_o = r_dst;
  assign len_o      = r_len;

endmodule

// File: doc/axi_lite_dma_ctrl_slave.md
Name: axi_lite_dma_ctrl_slave

Overview:
- AXI4-Lite responder (slave) register file for the MM2S->S2MM copy engine; it is the far end of the control transactions that the VIP master issues.
- Holds source address, destination address and byte length. Generates a one-cycle start pulse to the engine and records the engine's done/idle status.
- Sits between the AXI interconnect (base 0x4000_0000) and the copy engine's control inputs.

Parameters:
- ADDR_WIDTH, 12, AXI-Lite address bits decoded (offset within the 4 KB window).
- DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- LEN_WIDTH, 32, width of the length register in bytes.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake
- start_o  out  1  one-cycle start pulse to the engine
- src_addr_o  out  32  SRC register
- dst_addr_o  out  32  DST register
- len_o  out  LEN_WIDTH  LEN register
- done_i  in  1  one-cycle pulse from the engine when a transfer completes

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: bit0 START. Write 1 produces a pulse; reads return 0.
  - 0x04 STATUS: bit0 DONE (sticky), bit1 IDLE. Write 1 to bit0 clears DONE (W1C).
  - 0x10 SRC (RW).
  - 0x14 DST (RW).
  - 0x18 LEN (RW).
- Reset (aresetn low at a rising edge):
  - All AXI ready/valid outputs = 0; bresp/rresp = 0; rdata = 0.
  - SRC = DST = LEN = 0; DONE = 0; IDLE = 1; start_o = 0.
  - Any in-flight transaction is dropped with no response.
- Write channel, FSM W_IDLE -> W_RESP:
  - In W_IDLE, awready = wready = 1. AW and W are captured independently, in either order or in the same cycle.
  - Once both are held, the register update occurs on that edge and the FSM enters W_RESP with bvalid = 1 on the next cycle.
  - While one channel is held, its ready = 0 until the B handshake completes.
  - bvalid stays high until bready; then return to W_IDLE.
  - Exactly one write is outstanding at a time.
- wstrb: each byte lane is written only when its strobe bit is 1. CTRL/STATUS act only on bit0 when wstrb[0] = 1.
- Read channel, FSM R_IDLE -> R_DATA:
  - arready = 1 in R_IDLE. On AR handshake, rdata/rresp are registered and rvalid = 1 on the next cycle.
  - rvalid and rdata are held stable until rready.
  - arready = 0 while in R_DATA.
- Response codes:
  - Mapped offsets: OKAY (00).
  - Unmapped offsets: SLVERR (10). Writes to unmapped offsets are discarded; reads return 0.
- Start:
  - A CTRL write with bit0 = 1 while IDLE = 1 asserts start_o for exactly one cycle, on the cycle after the W/AW capture edge.
  - On that same edge IDLE is cleared and DONE is cleared.
  - A START write while IDLE = 0 is ignored (no pulse) but still returns OKAY.
- Done:
  - done_i = 1 sets DONE = 1 and IDLE = 1 on the next edge, so STATUS reads 0x3.
  - If done_i and a W1C of DONE occur on the same edge, done_i wins and DONE = 1.
  - done_i while IDLE = 1 still sets DONE.
- SRC/DST/LEN writes while busy update the registers and outputs immediately. The engine latches its configuration at start_o, so this is legal.
- Simultaneous read and write to the same register: the read returns the pre-write value.

Decomposition:
- Shared package axi_lite_dma_pkg holds:
  - Register offset localparams: CTRL 0x00, STATUS 0x04, SRC 0x10, DST 0x14, LEN 0x18.
  - STATUS bit indices.
  - Response enum (OKAY, SLVERR).
  - FSM state typedefs.
- One natural sub-module, axi_lite_slave_if: the AW/W/B/AR/R handshake logic. It presents wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data with a one-cycle read latency to the register bank in the top module.

Test Plan:
- Reset, then read 0x04 -> rdata 0x2, OKAY; reads of 0x10/0x14/0x18 -> 0.
- Write SRC = 0xC000_0000, DST = 0xC000_1000, LEN = 4096 -> read back identical values; src_addr_o/dst_addr_o/len_o match; bresp OKAY.
- Write 0x00 = 1 -> start_o high for exactly 1 cycle; STATUS reads 0x0. A second START before done_i -> no pulse.
- Pulse done_i -> STATUS reads 0x3. Write 0x04 = 1 -> STATUS reads 0x2. Issue done_i on the same edge as the W1C -> STATUS reads 0x3.
- Drive AW 3 cycles before W, then W before AW, with bready held low for 4 cycles -> single correct update; bvalid stable until bready. rready held low -> rdata stable.
- Write SRC with wstrb = 0b0101, data 0xAABBCCDD, over a prior 0x11223344 -> SRC reads 0x11BB33DD. Read of 0x08 -> 0 with SLVERR.
